// File: rtl/ucdp_clk_div.sv
// Glitch-free programmable integer clock divider, ratio R = div_i + 2.
// Ratio changes and stop requests only take effect at period boundaries.
module ucdp_clk_div #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_an_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] div_i,
  output logic             clk_o,
  output logic             stb_o,
  output logic             busy_o
);

  localparam int unsigned CW = WIDTH + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] ratio_q;
  logic [CW-1:0] ratio_d;
  logic [CW-1:0] ratio_new;
  logic [CW-1:0] half;
  logic          clk_d;
  logic          stb_d;
  logic          busy_d;
  logic          high_end;
  logic          per_end;

  // High phase takes the ceiling so odd ratios run one cycle longer high.
  assign ratio_new = CW'(div_i) + CW'(2);
  assign half      = (ratio_q + CW'(1)) >> 1;
  assign high_end  = (cnt_q == half - CW'(1));
  assign per_end   = (cnt_q == ratio_q - CW'(1));

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en_i) state_d = RUN;
      RUN:  if (per_end && !en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    clk_d   = clk_o;
    stb_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en_i) begin
          ratio_d = ratio_new;
          clk_d   = 1'b1;
          stb_d   = 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (high_end) clk_d = 1'b0;
        if (per_end) begin
          cnt_d = '0;
          clk_d = 1'b0;
          if (en_i) begin
            ratio_d = ratio_new;
            clk_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end
      default: begin
        cnt_d = '0;
        clk_d = 1'b0;
      end
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      cnt_q   <= '0;
      ratio_q <= CW'(2);
      clk_o   <= 1'b0;
      stb_o   <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      clk_o   <= clk_d;
      stb_o   <= stb_d;
      busy_o  <= busy_d;
    end
  end

`ifndef SYNTHESIS
`ifndef UCDP_NO_CLK_VERIF
  // div_i only matters at edges where a new period may start.
  always @(posedge clk_i) begin
    if (rst_an_i === 1'b1) begin
      if ($isunknown(en_i)) $display("SIMERROR: %m");
      if (((state_q == IDLE) || per_end) && $isunknown(div_i))
        $display("SIMERROR: %m");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_ucdp_clk_div.sv
// Directed bench for ucdp_clk_div; expected waveforms derived from
// the ratio per period (high = ceil(R/2), strobe in first cycle).
module tb_ucdp_clk_div;

  logic       clk_i;
  logic       rst_an_i;
  logic       en_i;
  logic [3:0] div_i;
  logic       clk_o;
  logic       stb_o;
  logic       busy_o;

  int errs;
  int checks;

  ucdp_clk_div #(.WIDTH(4)) dut (
    .clk_i    (clk_i),
    .rst_an_i (rst_an_i),
    .en_i     (en_i),
    .div_i    (div_i),
    .clk_o    (clk_o),
    .stb_o    (stb_o),
    .busy_o   (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full period of ratio r; at cycle p==at, drive new div/en.
  task automatic run_period(input string tag, input int r, input int at,
                            input logic [3:0] nd, input logic ne);
    int h;
    h = (r + 1) / 2;
    for (int p = 0; p < r; p++) begin
      @(negedge clk_i);
      chk($sformatf("%s.clk[%0d]", tag, p), 32'(clk_o), 32'(p < h));
      chk($sformatf("%s.stb[%0d]", tag, p), 32'(stb_o), 32'(p == 0));
      chk($sformatf("%s.busy[%0d]", tag, p), 32'(busy_o), 32'd1);
      if (p == at) begin
        div_i = nd;
        en_i  = ne;
      end
    end
  endtask

  initial begin
    errs     = 0;
    checks   = 0;
    rst_an_i = 1'b0;
    en_i     = 1'b0;
    div_i    = 4'd0;
    #12;
    chk("rst_outs", 32'({clk_o, stb_o, busy_o}), 32'd0);
    @(negedge clk_i);
    rst_an_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk($sformatf("idle[%0d]", i), 32'({clk_o, stb_o, busy_o}), 32'd0);
    end

    // R=2, then R=3, then R=17
    en_i  = 1'b1;
    div_i = 4'd0;
    run_period("r2a", 2, -1, 4'd0, 1'b1);
    run_period("r2b", 2, -1, 4'd0, 1'b1);
    run_period("r2c", 2, 1, 4'd1, 1'b1);
    run_period("r3a", 3, -1, 4'd1, 1'b1);
    run_period("r3b", 3, 2, 4'd15, 1'b1);
    run_period("r17a", 17, -1, 4'd15, 1'b1);
    run_period("r17b", 17, 16, 4'd0, 1'b1);

    // R=2 with mid-period change to div=3
    run_period("r2d", 2, 0, 4'd3, 1'b1);
    run_period("r5a", 5, -1, 4'd3, 1'b1);
    run_period("r5b", 5, 4, 4'd4, 1'b1);

    // R=6, drop en in 2nd high cycle
    run_period("r6a", 6, -1, 4'd4, 1'b1);
    run_period("r6b", 6, 1, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk($sformatf("stop[%0d]", i), 32'({clk_o, stb_o, busy_o}), 32'd0);
    end
    en_i = 1'b1;
    run_period("r6c", 6, 5, 4'd2, 1'b1);

    // R=4, async reset in high phase
    run_period("r4a", 4, -1, 4'd2, 1'b1);
    @(negedge clk_i);
    chk("pre_rst_clk", 32'(clk_o), 32'd1);
    #2;
    rst_an_i = 1'b0;
    #1;
    chk("async_rst", 32'({clk_o, stb_o, busy_o}), 32'd0);
    @(negedge clk_i);
    chk("in_rst", 32'({clk_o, stb_o, busy_o}), 32'd0);
    rst_an_i = 1'b1;
    run_period("r4b", 4, -1, 4'd2, 1'b1);
    run_period("r4c", 4, -1, 4'd2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
